boxcar_avg_filter: RTL and testbench
====================================

// Module: boxcar_avg_filter
//
// PURPOSE
//   Parametrised N-tap moving-average (boxcar) filter with valid qualifier, N = 2**LOG2_LEN.
//   Keeps a circular window of the last N samples and a running sum; outputs sum/N.
//   Generalises the fixed 8-bit pass-through stage: width, window depth and signedness are set by parameters.
//   Sits in the sample path between an ADC/stream source and downstream DSP stages.
//
// PARAMETERS
//   DATA_W    8  sample width in/out, bits (2..32)
//   LOG2_LEN  3  log2 of window length N (1..8)
//   SIGNED    0  0 = unsigned samples; 1 = two's-complement samples, arithmetic shift
//
// PORTS
//   i_clk     in   1                  clock, all logic on rising edge
//   i_reset_n in   1                  synchronous, active-low reset
//   i_valid   in   1                  i_data holds a new sample this cycle
//   i_data    in   DATA_W             input sample
//   i_clear   in   1                  synchronous flush of the window, sum and count
//   o_valid   out  1                  o_data/o_sum updated this cycle
//   o_data    out  DATA_W             window average
//   o_sum     out  DATA_W+LOG2_LEN    running window sum (full precision)
//   o_primed  out  1                  N samples accepted since the last reset or clear
//
// BEHAVIOUR
//   - Reset (i_reset_n=0 at a clock edge): all window registers, the sum, the write pointer and the fill count go to 0.
//     Outputs o_valid, o_data, o_sum and o_primed go to 0.
//   - Window: N registers of DATA_W bits, written at pointer wr_ptr (LOG2_LEN bits).
//     wr_ptr increments on each accepted sample and wraps N-1 -> 0 with no special case.
//   - Accept (i_valid=1, i_clear=0):
//     - sum_nxt = sum + ext(i_data) - ext(win[wr_ptr]), in ACC_W = DATA_W+LOG2_LEN bits.
//     - ext() zero-extends when SIGNED=0 and sign-extends when SIGNED=1.
//     - Then win[wr_ptr] <= i_data, sum <= sum_nxt and wr_ptr++.
//   - Output latency is 1 cycle: on the edge after an accept, o_valid=1, o_sum=sum_nxt and o_data=avg(sum_nxt).
//   - avg() is sum >> LOG2_LEN, using a logical shift when SIGNED=0 and an arithmetic shift when SIGNED=1.
//     The result always fits in DATA_W bits, so no saturation is needed.
//   - i_valid=0: o_valid=0 next cycle; o_data, o_sum and o_primed hold their values.
//   - Start-up: the window is pre-filled with zeros, so the first N-1 outputs are a ramp (partial sum / N).
//   - Fill count: saturates at N; o_primed=1 from the output cycle of the Nth accepted sample onward.
//   - i_clear=1: same effect as reset on the window, sum, pointer, count, o_sum, o_data and o_primed.
//     o_valid=0 next cycle.
//   - Simultaneous i_clear=1 with i_valid=1: the clear wins and the sample is dropped.
//   - Reset mid-stream: identical to a clear; no stale window content survives.
//   - No backpressure: a sample is accepted every cycle i_valid=1, so one sample per clock is sustained.
//
// CONFIGURATION
//   BOXCAR_ROUND_EN defined:
//     avg = (sum + 2**(LOG2_LEN-1)) >> LOG2_LEN, computed in ACC_W+1 bits so it cannot overflow.
//     Rounds half toward +inf in both signed and unsigned modes.
//   BOXCAR_ROUND_EN undefined: avg = sum >> LOG2_LEN (floor). o_sum is unaffected in either case.
//
// TESTING   (DATA_W=8, LOG2_LEN=2 so N=4, SIGNED=0 unless stated)
//   1. Reset with i_valid=1 and i_data=0xFF, then release reset:
//      -> o_valid=0, o_data=0, o_sum=0, o_primed=0 during reset.
//   2. Step input 100 for 5 consecutive valid cycles:
//      -> o_data = 25,50,75,100,100; o_sum = 100..400; o_primed=1 from the 4th output.
//   3. Input 255 for 4 valid cycles:
//      -> o_sum = 1020 (no overflow); o_data = 63,127,191,255.
//   4. Inputs 1,1:
//      -> o_sum = 1,2; o_data = 0,0 without the macro; o_data = 0,1 with BOXCAR_ROUND_EN.
//   5. Primed at 100, then i_valid and i_clear together with i_data=40, then one valid 40:
//      -> first sample dropped; next output o_data=10, o_sum=40, o_primed=0.
//   6. SIGNED=1, input 0xF8 (-8) for 4 valid cycles with gaps of 2 idle cycles between them:
//      -> o_data = 0xFE,0xFC,0xFA,0xF8; o_valid only on the cycle after each accept; outputs hold during gaps.

Source files
------------

// File: rtl/boxcar_avg_filter.sv
// rtl/boxcar_avg_filter.sv - N-tap moving-average filter with a running sum and a valid qualifier.
// Define BOXCAR_ROUND_EN to round the average half toward +inf instead of flooring it.
module boxcar_avg_filter #(
  parameter int DATA_W   = 8,
  parameter int LOG2_LEN = 3,
  parameter int SIGNED   = 0
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_valid,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_clear,
  output logic                         o_valid,
  output logic [DATA_W-1:0]            o_data,
  output logic [DATA_W+LOG2_LEN-1:0]   o_sum,
  output logic                         o_primed
);

  localparam int N     = 1 << LOG2_LEN;
  localparam int ACC_W = DATA_W + LOG2_LEN;
  localparam int CNT_W = LOG2_LEN + 1;

  logic [DATA_W-1:0]   win [N];
  logic [LOG2_LEN-1:0] wr_ptr;
  logic [CNT_W-1:0]    fill_cnt;
  logic [ACC_W-1:0]    sum_nxt;
  logic [DATA_W-1:0]   avg_nxt;

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] d);
    ext = {{LOG2_LEN{(SIGNED != 0) & d[DATA_W-1]}}, d};
  endfunction

  // o_sum doubles as the running window sum; it only changes on accept or flush.
  assign sum_nxt = o_sum + ext(i_data) - ext(win[wr_ptr]);

`ifdef BOXCAR_ROUND_EN
  // One guard bit keeps sum + N/2 from wrapping; the rounded average still fits DATA_W.
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (LOG2_LEN - 1);
  logic [ACC_W:0] rnd_sum;
  assign rnd_sum = {(SIGNED != 0) & sum_nxt[ACC_W-1], sum_nxt} + HALF;
  assign avg_nxt = rnd_sum[ACC_W-1:LOG2_LEN];
`else
  // The shifted-in bits fall outside DATA_W, so a plain slice serves both logical and arithmetic shift.
  assign avg_nxt = sum_nxt[ACC_W-1:LOG2_LEN];
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      for (int i = 0; i < N; i++) begin
        win[i] <= '0;
      end
      wr_ptr   <= '0;
      fill_cnt <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_sum    <= '0;
      o_primed <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        win[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + LOG2_LEN'(1);
        if (fill_cnt != CNT_W'(N)) begin
          fill_cnt <= fill_cnt + CNT_W'(1);
        end
        o_sum    <= sum_nxt;
        o_data   <= avg_nxt;
        o_primed <= (fill_cnt >= CNT_W'(N - 1));
      end
    end
  end

endmodule

// File: tb/tb_boxcar_avg_filter.sv
// tb/tb_boxcar_avg_filter.sv - randomized and directed bench for boxcar_avg_filter against a queue-based model.
module tb_boxcar_avg_filter;

  localparam int DW = 8;
  localparam int LG = 2;
  localparam int NN = 4;
`ifdef BOXCAR_ROUND_EN
  localparam int ROUND = 1;
`else
  localparam int ROUND = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, valid, clear;
  logic [DW-1:0] data;
  logic          u_valid, s_valid, u_primed, s_primed;
  logic [DW-1:0] u_data, s_data;
  logic [DW+LG-1:0] u_sum, s_sum;

  int checks = 0;
  int errors = 0;

  int hist_u[$];
  int hist_s[$];
  int accepted;
  int ev, ep, ed_u, es_u, ed_s, es_s;

  always #5 clk = ~clk;

  boxcar_avg_filter #(.DATA_W(DW), .LOG2_LEN(LG), .SIGNED(0)) u_dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_data(data), .i_clear(clear),
    .o_valid(u_valid), .o_data(u_data), .o_sum(u_sum), .o_primed(u_primed)
  );

  boxcar_avg_filter #(.DATA_W(DW), .LOG2_LEN(LG), .SIGNED(1)) s_dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_data(data), .i_clear(clear),
    .o_valid(s_valid), .o_data(s_data), .o_sum(s_sum), .o_primed(s_primed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int floordiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model(input logic rstn, input logic v, input logic clr, input logic [DW-1:0] d);
    int su, ss;
    if (!rstn || clr) begin
      hist_u.delete(); hist_s.delete();
      accepted = 0;
      ev = 0; ep = 0; ed_u = 0; es_u = 0; ed_s = 0; es_s = 0;
    end else if (v) begin
      hist_u.push_back(int'(d));
      hist_s.push_back(int'($signed(d)));
      if (hist_u.size() > NN) begin
        void'(hist_u.pop_front());
        void'(hist_s.pop_front());
      end
      accepted++;
      su = qsum(hist_u);
      ss = qsum(hist_s);
      ev = 1;
      ep = (accepted >= NN) ? 1 : 0;
      es_u = su & ((1 << (DW + LG)) - 1);
      es_s = ss & ((1 << (DW + LG)) - 1);
      ed_u = floordiv(su + ROUND * (NN / 2), NN) & ((1 << DW) - 1);
      ed_s = floordiv(ss + ROUND * (NN / 2), NN) & ((1 << DW) - 1);
    end else begin
      ev = 0;
    end
  endtask

  task automatic step(input logic rstn, input logic v, input logic clr, input logic [DW-1:0] d);
    reset_n = rstn; valid = v; clear = clr; data = d;
    @(posedge clk);
    model(rstn, v, clr, d);
    #1;
    check("u_valid", u_valid, ev);
    check("u_data", u_data, ed_u);
    check("u_sum", u_sum, es_u);
    check("u_primed", u_primed, ep);
    check("s_valid", s_valid, ev);
    check("s_data", s_data, ed_s);
    check("s_sum", s_sum, es_s);
    check("s_primed", s_primed, ep);
  endtask

  initial begin
    reset_n = 1'b0; valid = 1'b1; clear = 1'b0; data = 8'hFF;

    // Reset while a sample is offered.
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    check("rst_valid", u_valid, 0);
    check("rst_data", u_data, 0);
    check("rst_sum", u_sum, 0);
    check("rst_primed", u_primed, 0);

    // Step of 100.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'd100);
      check("step_data", u_data, (i < 4) ? 25 * (i + 1) : 100);
      check("step_sum", u_sum, (i < 4) ? 100 * (i + 1) : 400);
      check("step_primed", u_primed, (i >= 3) ? 1 : 0);
    end

    // Clear together with valid drops the sample.
    step(1'b1, 1'b1, 1'b1, 8'd40);
    check("clr_valid", u_valid, 0);
    check("clr_primed", u_primed, 0);
    step(1'b1, 1'b1, 1'b0, 8'd40);
    check("clr_next_data", u_data, 10);
    check("clr_next_sum", u_sum, 40);
    check("clr_next_primed", u_primed, 0);

    // Full-scale input must not overflow the sum.
    step(1'b1, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'd255);
    check("full_sum", u_sum, 1020);
    check("full_data", u_data, 255);

    // Small values expose floor versus rounding.
    step(1'b1, 1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b1, 1'b0, 8'd1);
    check("ones_data0", u_data, 0);
    step(1'b1, 1'b1, 1'b0, 8'd1);
    check("ones_sum1", u_sum, 2);
    check("ones_data1", u_data, ROUND);

    // Negative samples with idle gaps on the signed instance.
    step(1'b1, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'hF8);
      check("neg_valid", s_valid, 1);
      check("neg_data", s_data, 8'hFE - 2 * i);
      for (int g = 0; g < 2; g++) begin
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("gap_valid", s_valid, 0);
        check("gap_hold", s_data, 8'hFE - 2 * i);
      end
    end

    // Random traffic including clears and mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 4), DW'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
